// File: rtl/softmax_normalize.sv
// -----------------------------------------------------------------------------
// softmax_normalize
//
// Final stage of the softmax datapath. Collects a vector of up to N_MAX exp
// words {position, mantissa}, aligns each one to a 32-bit Q16.16 value while
// accumulating their sum, then divides every buffered value by the sum with a
// serial restoring divider. The results leave as unsigned Q0.16 probabilities
// on a valid/ready stream.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   in_valid       input beat valid
//   in_ready       block accepts an input beat (only while loading)
//   in_data        exp word: [PW+MW-1:MW] = position p, [MW-1:0] = mantissa m
//   in_last        final element of the vector
//   out_valid      probability beat valid
//   out_ready      downstream accepts the probability beat
//   out_data       probability, unsigned Q0.QW
//   out_last       final probability of the vector
//   busy           high whenever a vector is in progress
//   err_zero_sum   sticky per vector: the sum was zero
//   err_sat        sticky per vector: some input had p > 16 (clamped)
// -----------------------------------------------------------------------------
module softmax_normalize #(
   parameter int N_MAX = 8,
   parameter int MW    = 16,
   parameter int PW    = 5,
   parameter int QW    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PW+MW-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [QW-1:0]    out_data,
   output logic             out_last,
   output logic             busy,
   output logic             err_zero_sum,
   output logic             err_sat
);

   localparam int SW  = 32 + $clog2(N_MAX);              // sum width, cannot overflow
   localparam int RW  = SW + 1;                          // remainder holds 2*sum
   localparam int CW  = $clog2(N_MAX + 1);               // count 0..N_MAX
   localparam int IW  = (N_MAX > 1) ? $clog2(N_MAX) : 1; // element index
   localparam int STW = $clog2(QW + 1);                  // divider step 0..QW

   typedef enum logic [1:0] {
      LOAD,
      DIV,
      OUT
   } state_t;

   state_t        state, state_next;
   logic [CW-1:0] count;
   logic [IW-1:0] idx;
   logic [SW-1:0] sum;
   logic [STW-1:0] step;
   logic [RW-1:0] rem;
   logic [QW-1:0] quot;
   logic [31:0]   buf_mem [N_MAX];

   // Input alignment: value = m * 2^(p-16), so Q16.16 is simply m << p.
   logic [PW-1:0] pos;
   logic [MW-1:0] mant;
   logic          sat_in;
   logic [PW-1:0] shamt;
   logic [31:0]   aligned;

   assign pos     = in_data[MW +: PW];
   assign mant    = in_data[MW-1:0];
   assign sat_in  = (pos > PW'(16));
   assign shamt   = sat_in ? PW'(16) : pos;
   assign aligned = 32'(mant) << shamt;

   logic            in_fire, out_fire, beat_last, last_elem, zero_sum, rem_ge;
   logic [RW-1:0]   rem_sh;

   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   // The N_MAX-th beat closes the vector whatever in_last says.
   assign beat_last = in_last || (count == CW'(N_MAX - 1));
   assign last_elem = (CW'(idx) == count - CW'(1));
   assign zero_sum  = (sum == '0);
   assign rem_sh    = {rem[RW-2:0], 1'b0};
   assign rem_ge    = (rem_sh >= RW'(sum));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LOAD;
      else        state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a signal unassigned and infer a latch.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid && beat_last) state_next = DIV;
         end
         DIV: begin
            // Step 0 loads the remainder (or short-cuts a zero sum);
            // steps 1..QW each produce one quotient bit, MSB first.
            if ((step == '0 && zero_sum) || step == STW'(QW)) state_next = OUT;
         end
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_next = last_elem ? LOAD : DIV;
         end
         default: state_next = LOAD;
      endcase
   end

   assign out_last = out_valid && last_elem;
   assign busy     = (state != LOAD) || (count != '0);
   assign out_data = quot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count        <= '0;
         idx          <= '0;
         sum          <= '0;
         step         <= '0;
         rem          <= '0;
         quot         <= '0;
         err_zero_sum <= 1'b0;
         err_sat      <= 1'b0;
      end else begin
         case (state)
            LOAD: begin
               if (in_fire) begin
                  count <= count + CW'(1);
                  sum   <= sum + SW'(aligned);
                  idx   <= '0;
                  step  <= '0;
                  // Error flags belong to one vector: restart them on its first beat.
                  if (count == '0) begin
                     err_sat      <= sat_in;
                     err_zero_sum <= 1'b0;
                  end else if (sat_in) begin
                     err_sat <= 1'b1;
                  end
               end
            end
            DIV: begin
               if (step == '0) begin
                  step <= STW'(1);
                  if (zero_sum) begin
                     quot         <= '0;
                     err_zero_sum <= 1'b1;
                  end else begin
                     rem <= RW'(buf_mem[idx]);
                  end
               end else begin
                  // When buf[idx] equals the sum the remainder stays at sum and
                  // every bit comes out 1, giving the all-ones saturation value.
                  rem  <= rem_ge ? rem_sh - RW'(sum) : rem_sh;
                  quot <= {quot[QW-2:0], rem_ge};
                  step <= step + STW'(1);
               end
            end
            OUT: begin
               if (out_fire) begin
                  step <= '0;
                  if (last_elem) begin
                     count <= '0;
                     sum   <= '0;
                  end else begin
                     idx <= idx + IW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: the vector buffer is deliberately not reset; each entry is written
   // before it is read within a vector, so reset would only cost flops.
   always_ff @(posedge clk) begin
      if (in_fire) buf_mem[count[IW-1:0]] <= aligned;
   end

endmodule
